spi_result_tx: RTL

- Parametrised SPI-slave transmit controller that returns a host-selected result word on MISO.
- Generalises the single digit/cost output path to NUM_CH result channels of DATA_W bits, with selectable bit order.
- Supports two request sources: a host read command (received byte from the SPI input side) and an autonomous push request (e.g. network done).
- Sits between the SPI receive block (which supplies command bytes and synchronised SCK shift strobes) and the result producers (network, cost unit).

---
 rtl/spi_result_tx_if.sv | 29 ++
 rtl/spi_result_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spi_result_tx_if.sv
// Bus bundle for spi_result_tx: SPI-side strobes, host command input and the
// per-channel result handshake.
interface spi_result_tx_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int CMD_W  = 8
);
  logic                     SS;
  logic                     shift_edge;
  logic                     cmd_valid;
  logic [CMD_W-1:0]         cmd_byte;
  logic                     auto_req;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     busy;
  logic                     frame_done;
  logic                     cmd_err;

  modport slave (
    input  SS, shift_edge, cmd_valid, cmd_byte, auto_req, ch_data, ch_valid,
    output ch_ack, busy, frame_done, cmd_err
  );

  modport master (
    output SS, shift_edge, cmd_valid, cmd_byte, auto_req, ch_data, ch_valid,
    input  ch_ack, busy, frame_done, cmd_err
  );
endinterface

// File: rtl/spi_result_tx.sv
// SPI-slave transmit controller: loads a host-selected (or auto-pushed) result
// word into a shift register and serialises it on MISO, one bit per shift edge.
module spi_result_tx #(
  parameter int DATA_W    = 8,
  parameter int NUM_CH    = 4,
  parameter int CMD_W     = 8,
  parameter int LSB_FIRST = 1,
  parameter int AUTO_CH   = 0
) (
  input  logic            clk,
  input  logic            n_rst,
  spi_result_tx_if.slave  bus,
  output logic            MISO
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CMD_W-2:0] NUM_CH_C = (CMD_W-1)'(NUM_CH);
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT_DATA, LOAD, SHIFT} state_t;

  state_t            state_r;
  logic [DATA_W-1:0] sr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  sel_r;
  logic              ss_d_r;
  logic [NUM_CH-1:0] ch_ack_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              cmd_err_r;

  logic              shift_s;
  logic              last_s;
  logic              ss_rise_s;
  logic              cmd_read_s;
  logic              cmd_ok_s;
  logic [IDX_W-1:0]  cmd_idx_s;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] sr_shift_s;
  logic              out_bit_s;

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) v[k] = 1'b1;
      else                  v[k] = 1'b0;
    end
    return v;
  endfunction

  // Shift/frame strobes, command decode and output-bit selection
  always_comb begin
    shift_s    = bus.shift_edge & ~bus.SS & (state_r != LOAD);
    last_s     = shift_s & (cnt_r == CNT_W'(DATA_W - 1));
    ss_rise_s  = bus.SS & ~ss_d_r;
    cmd_read_s = bus.cmd_valid & bus.cmd_byte[CMD_W-1];
    // range test uses every index bit, not just the ones that address a channel
    cmd_ok_s   = (bus.cmd_byte[CMD_W-2:0] < NUM_CH_C);
    if (NUM_CH > 1) cmd_idx_s = bus.cmd_byte[IDX_W-1:0];
    else            cmd_idx_s = {IDX_W{1'b0}};
    word_s = bus.ch_data[sel_r*DATA_W +: DATA_W];
    if (LSB_FIRST != 0) begin
      sr_shift_s = {1'b1, sr_r[DATA_W-1:1]};
      out_bit_s  = sr_r[0];
    end else begin
      sr_shift_s = {sr_r[DATA_W-2:0], 1'b1};
      out_bit_s  = sr_r[DATA_W-1];
    end
  end

  // Control FSM, shift register, bit counter and registered status outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      sr_r         <= ONES;
      cnt_r        <= {CNT_W{1'b0}};
      sel_r        <= {IDX_W{1'b0}};
      ss_d_r       <= 1'b1;
      ch_ack_r     <= {NUM_CH{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      ss_d_r       <= bus.SS;
      ch_ack_r     <= {NUM_CH{1'b0}};
      frame_done_r <= last_s;
      cmd_err_r    <= 1'b0;
      if (shift_s) begin
        sr_r  <= sr_shift_s;
        cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
      if (ss_rise_s) begin
        state_r <= IDLE;
        cnt_r   <= {CNT_W{1'b0}};
        sr_r    <= ONES;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.auto_req) begin
              sel_r    <= IDX_W'(AUTO_CH);
              ch_ack_r <= onehot(IDX_W'(AUTO_CH));
              state_r  <= LOAD;
              busy_r   <= 1'b1;
            end else if (cmd_read_s && cmd_ok_s) begin
              sel_r   <= cmd_idx_s;
              state_r <= WAIT_DATA;
              busy_r  <= 1'b1;
            end else if (cmd_read_s) begin
              cmd_err_r <= 1'b1;
            end
          end
          WAIT_DATA: begin
            // host clocked out a whole frame before data arrived: it reads all ones
            if (last_s) begin
              state_r <= IDLE;
              sr_r    <= ONES;
              busy_r  <= 1'b0;
            end else if (bus.ch_valid[sel_r]) begin
              ch_ack_r <= onehot(sel_r);
              state_r  <= LOAD;
            end
          end
          LOAD: begin
            sr_r    <= word_s;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= SHIFT;
          end
          SHIFT: begin
            if (last_s) begin
              state_r <= IDLE;
              sr_r    <= ONES;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            sr_r    <= ONES;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ch_ack     = ch_ack_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.cmd_err    = cmd_err_r;
  assign MISO           = bus.SS ? 1'bz : out_bit_s;
endmodule
